data_mem_arbiter: RTL and testbench
===================================

// Module: data_mem_arbiter
// PURPOSE
//  Sits between the core's memory stage / LCD reader and the data memory; arbitrates one shared
//  port. CPU (read/write) and LCD reader (read-only) both request; one memory command per grant.
//  Non-pipelined: one read in flight at a time. Returns read data to the owner of the read.
//  Issues cpu_stall so the core holds its memory-stage operands while it waits for a grant.
// PARAMETERS
//  ADDR_WIDTH    32  address width, all ports
//  DATA_WIDTH    32  data width, all ports
//  RD_LAT        1   memory read latency in cycles (1..4); mem_rdata valid RD_LAT cycles after mem_rd_en
//  STARVE_LIMIT  4   LCD denied-cycle threshold (used only with ARB_STARVE_GUARD_EN)
// PORTS
//  clk        in   1           system clock, rising edge
//  rst        in   1           synchronous reset, active-high
//  cpu_req    in   1           CPU memory request; hold with fields stable until cpu_gnt
//  cpu_we     in   1           1 = write, 0 = read
//  cpu_addr   in   ADDR_WIDTH  CPU address
//  cpu_wdata  in   DATA_WIDTH  CPU write data
//  cpu_gnt    out  1           CPU command issued this cycle (combinational)
//  cpu_stall  out  1           cpu_req & ~cpu_gnt
//  cpu_rvalid out  1           one-cycle pulse, cpu_rdata valid
//  cpu_rdata  out  DATA_WIDTH  registered CPU read data, held until next CPU capture
//  lcd_req    in   1           LCD read request; hold with lcd_addr stable until lcd_gnt
//  lcd_addr   in   ADDR_WIDTH  LCD read address
//  lcd_gnt    out  1           LCD command issued this cycle (combinational)
//  lcd_rvalid out  1           one-cycle pulse, lcd_rdata valid
//  lcd_rdata  out  DATA_WIDTH  registered LCD read data, held until next LCD capture
//  mem_addr   out  ADDR_WIDTH  to data memory; muxed from granted requester, 0 when no grant
//  mem_wdata  out  DATA_WIDTH  to data memory; cpu_wdata on CPU write grant, else 0
//  mem_rd_en  out  1           memory read strobe (grant cycle of a read)
//  mem_wr_en  out  1           memory write strobe (grant cycle of a CPU write)
//  mem_rdata  in   DATA_WIDTH  memory read data
// BEHAVIOUR
//  Reset: state IDLE, latency counter 0, owner 0, cpu/lcd_rvalid 0, cpu/lcd_rdata 0;
//   while rst=1 all gnt, mem_rd_en, mem_wr_en forced 0. Reset mid-read discards the read; no rvalid.
//  FSM IDLE: grants only here. Both req -> CPU wins (see CONFIGURATION). Winner gets gnt=1 same cycle.
//   CPU write: mem_wr_en=1, stay IDLE; back-to-back writes, one per cycle.
//   Read (either): mem_rd_en=1, record owner, load counter RD_LAT, go WAIT.
//  FSM WAIT: all gnt=0, mem strobes 0. Decrement counter; at count 1, register mem_rdata into
//   owner's rdata, set owner's rvalid for the next cycle, go IDLE.
//  Timing: read granted cycle T -> rvalid high in cycle T+RD_LAT+1; a new grant may issue in that
//   same cycle. Read throughput: one read per RD_LAT+1 cycles.
//  req dropped before grant: legal, no effect. req held after gnt: treated as a new request.
//  cpu_rvalid and lcd_rvalid never high together; rdata of the other port unchanged.
// CONFIGURATION
//  ARB_STARVE_GUARD_EN defined: counter increments in each IDLE cycle with lcd_req=1 and lcd_gnt=0;
//   when it equals STARVE_LIMIT, LCD wins the next IDLE arbitration over CPU (CPU stalls).
//   Counter clears on lcd_gnt or lcd_req=0, and on rst.
//  Not defined: strict CPU priority; LCD may starve; counter logic absent; STARVE_LIMIT unused.
// TESTING
//  CPU write addr 0x10 data 0xDEADBEEF, RD_LAT=1 -> same cycle cpu_gnt=1, mem_wr_en=1, mem_addr=0x10.
//  CPU read 0x10 granted T -> mem_rd_en at T; cpu_rvalid=1, cpu_rdata=0xDEADBEEF at T+2; lcd_rvalid=0.
//  cpu_req & lcd_req same cycle (both reads) -> cpu_gnt T, cpu_stall=0, lcd_gnt T+2, lcd_rvalid T+4.
//  RD_LAT=3 LCD read 0x20 granted T, rst=1 at T+2 -> no lcd_rvalid, state IDLE, all outputs 0.
//  Guard on, STARVE_LIMIT=4, CPU write-streams while lcd_req held -> lcd_gnt after 4 denied cycles,
//   cpu_stall=1 that cycle; guard off -> lcd_gnt only once cpu_req drops.
//  Back-to-back CPU writes 0x0..0x3 -> four consecutive mem_wr_en cycles, cpu_stall=0 throughout.

Source files
------------

// File: rtl/data_mem_arbiter.sv
// Shared data-memory port arbiter: CPU (read/write) vs LCD reader (read-only), one read in flight.
// Optional LCD anti-starvation guard enabled by defining ARB_STARVE_GUARD_EN.
module data_mem_arbiter #(
   parameter int unsigned ADDR_WIDTH   = 32,
   parameter int unsigned DATA_WIDTH   = 32,
   parameter int unsigned RD_LAT       = 1,
   parameter int unsigned STARVE_LIMIT = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  cpu_req,
   input  logic                  cpu_we,
   input  logic [ADDR_WIDTH-1:0] cpu_addr,
   input  logic [DATA_WIDTH-1:0] cpu_wdata,
   output logic                  cpu_gnt,
   output logic                  cpu_stall,
   output logic                  cpu_rvalid,
   output logic [DATA_WIDTH-1:0] cpu_rdata,
   input  logic                  lcd_req,
   input  logic [ADDR_WIDTH-1:0] lcd_addr,
   output logic                  lcd_gnt,
   output logic                  lcd_rvalid,
   output logic [DATA_WIDTH-1:0] lcd_rdata,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic [DATA_WIDTH-1:0] mem_wdata,
   output logic                  mem_rd_en,
   output logic                  mem_wr_en,
   input  logic [DATA_WIDTH-1:0] mem_rdata
);

   typedef enum logic {IDLE, WAIT} state_t;

   state_t     state, state_nxt;
   logic [2:0] lat_cnt, lat_cnt_nxt;
   logic       owner, owner_nxt;   // 1 = LCD owns the outstanding read
   logic       capture;
   logic       lcd_first;

`ifdef ARB_STARVE_GUARD_EN
   localparam int unsigned STARVE_W = $clog2(STARVE_LIMIT + 2);
   logic [STARVE_W-1:0] starve_cnt;

   // Counts IDLE cycles in which a pending LCD request lost arbitration
   always_ff @(posedge clk) begin
      if (rst) begin
         starve_cnt <= '0;
      end else if (!lcd_req || lcd_gnt) begin
         starve_cnt <= '0;
      end else if (state == IDLE && starve_cnt != STARVE_W'(STARVE_LIMIT)) begin
         starve_cnt <= starve_cnt + 1'b1;
      end
   end

   assign lcd_first = (starve_cnt == STARVE_W'(STARVE_LIMIT));
`else
   assign lcd_first = 1'b0;
`endif

   always_comb begin
      state_nxt   = state;
      lat_cnt_nxt = lat_cnt;
      owner_nxt   = owner;
      cpu_gnt     = 1'b0;
      lcd_gnt     = 1'b0;
      mem_addr    = '0;
      mem_wdata   = '0;
      mem_rd_en   = 1'b0;
      mem_wr_en   = 1'b0;
      capture     = 1'b0;
      if (!rst) begin
         case (state)
            IDLE: begin
               if (lcd_req && (!cpu_req || lcd_first)) begin
                  lcd_gnt     = 1'b1;
                  mem_addr    = lcd_addr;
                  mem_rd_en   = 1'b1;
                  owner_nxt   = 1'b1;
                  lat_cnt_nxt = 3'(RD_LAT);
                  state_nxt   = WAIT;
               end else if (cpu_req) begin
                  cpu_gnt  = 1'b1;
                  mem_addr = cpu_addr;
                  if (cpu_we) begin
                     mem_wr_en = 1'b1;
                     mem_wdata = cpu_wdata;
                  end else begin
                     mem_rd_en   = 1'b1;
                     owner_nxt   = 1'b0;
                     lat_cnt_nxt = 3'(RD_LAT);
                     state_nxt   = WAIT;
                  end
               end
            end
            WAIT: begin
               lat_cnt_nxt = lat_cnt - 3'd1;
               if (lat_cnt == 3'd1) begin
                  capture   = 1'b1;
                  state_nxt = IDLE;
               end
            end
            default: state_nxt = IDLE;
         endcase
      end
   end

   assign cpu_stall = cpu_req & ~cpu_gnt;

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         lat_cnt    <= '0;
         owner      <= 1'b0;
         cpu_rvalid <= 1'b0;
         lcd_rvalid <= 1'b0;
         cpu_rdata  <= '0;
         lcd_rdata  <= '0;
      end else begin
         state      <= state_nxt;
         lat_cnt    <= lat_cnt_nxt;
         owner      <= owner_nxt;
         cpu_rvalid <= capture & ~owner;
         lcd_rvalid <= capture & owner;
         if (capture && !owner) cpu_rdata <= mem_rdata;
         if (capture && owner)  lcd_rdata <= mem_rdata;
      end
   end

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Randomized scoreboard bench for data_mem_arbiter; honours ARB_STARVE_GUARD_EN when defined.
`timescale 1ns/1ps
module tb_data_mem_arbiter;

   localparam int unsigned AW           = 32;
   localparam int unsigned DW           = 32;
   localparam int unsigned RD_LAT       = 3;
   localparam int unsigned STARVE_LIMIT = 4;
   localparam int          NCYC         = 6000;
`ifdef ARB_STARVE_GUARD_EN
   localparam bit GUARD = 1'b1;
`else
   localparam bit GUARD = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          rst;
   logic          cpu_req, cpu_we, cpu_gnt, cpu_stall, cpu_rvalid;
   logic [AW-1:0] cpu_addr;
   logic [DW-1:0] cpu_wdata, cpu_rdata;
   logic          lcd_req, lcd_gnt, lcd_rvalid;
   logic [AW-1:0] lcd_addr;
   logic [DW-1:0] lcd_rdata;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_wdata, mem_rdata;
   logic          mem_rd_en, mem_wr_en;

   always #5 clk = ~clk;

   data_mem_arbiter #(
      .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RD_LAT(RD_LAT), .STARVE_LIMIT(STARVE_LIMIT)
   ) dut (
      .clk(clk), .rst(rst),
      .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
      .cpu_gnt(cpu_gnt), .cpu_stall(cpu_stall), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
      .lcd_req(lcd_req), .lcd_addr(lcd_addr), .lcd_gnt(lcd_gnt),
      .lcd_rvalid(lcd_rvalid), .lcd_rdata(lcd_rdata),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rd_en(mem_rd_en), .mem_wr_en(mem_wr_en),
      .mem_rdata(mem_rdata)
   );

   int errors = 0;
   int checks = 0;
   int cyc    = 0;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [DW-1:0] init_val(input logic [5:0] a);
      return ({a, 26'h0} ^ (32'h9E37_79B9 * {26'b0, a}) ^ 32'h1357_2468);
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s cyc=%0d got=%0h expected=%0h", name, cyc, act, exp);
      end
   endtask

   // Data memory: writes land on the strobe edge, read data valid RD_LAT cycles after the strobe
   logic [DW-1:0]             tb_mem [64];
   logic [63:0]               tb_wr = '0;
   logic [RD_LAT-1:0][5:0]    pa = '0;
   logic [RD_LAT-1:0]         pv = '0;
   always @(posedge clk) begin
      if (mem_wr_en) begin
         tb_mem[mem_addr[5:0]] <= mem_wdata;
         tb_wr[mem_addr[5:0]]  <= 1'b1;
      end
      pa[0] <= mem_addr[5:0];
      pv[0] <= mem_rd_en;
      for (int i = 1; i < RD_LAT; i++) begin
         pa[i] <= pa[i-1];
         pv[i] <= pv[i-1];
      end
   end
   always_comb begin
      mem_rdata = {16'hA5A5, 16'(cyc)};
      if (pv[RD_LAT-1])
         mem_rdata = tb_wr[pa[RD_LAT-1]] ? tb_mem[pa[RD_LAT-1]] : init_val(pa[RD_LAT-1]);
   end

   // Scoreboard of expected read responses
   typedef struct {
      bit            lcd;
      logic [DW-1:0] data;
      int            due;
   } rsp_t;
   rsp_t          exp_q[$];
   logic [DW-1:0] exp_crd = '0;
   logic [DW-1:0] exp_lrd = '0;
   bit            mon_en  = 1'b0;

   always @(negedge clk) begin
      if (mon_en) begin
         if (cpu_rvalid || lcd_rvalid) begin
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL rvalid_unexpected cyc=%0d cpu_rvalid=%b lcd_rvalid=%b expected none",
                        cyc, cpu_rvalid, lcd_rvalid);
            end else begin
               rsp_t e;
               e = exp_q.pop_front();
               chk("rvalid_both", {63'd0, cpu_rvalid & lcd_rvalid}, 64'd0);
               chk("rvalid_port", {63'd0, lcd_rvalid}, {63'd0, e.lcd});
               chk("rvalid_cycle", 64'(cyc), 64'(e.due));
               if (e.lcd) exp_lrd = e.data;
               else       exp_crd = e.data;
            end
         end else if (exp_q.size() > 0 && exp_q[0].due < cyc) begin
            checks++;
            errors++;
            $display("FAIL rvalid_missing cyc=%0d got=none expected lcd=%0b due=%0d",
                     cyc, exp_q[0].lcd, exp_q[0].due);
            void'(exp_q.pop_front());
         end
         chk("cpu_rdata", 64'(cpu_rdata), 64'(exp_crd));
         chk("lcd_rdata", 64'(lcd_rdata), 64'(exp_lrd));
         if (rst) begin
            while (exp_q.size() > 0 && exp_q[$].due > cyc) void'(exp_q.pop_back());
            exp_crd = '0;
            exp_lrd = '0;
         end
      end
   end

   // Reference model: port free again RD_LAT+1 cycles after a read grant
   logic [DW-1:0] model_mem [64];
   int            busy_until = 0;
   int            denied     = 0;
   bit            cpu_done   = 1'b0;
   bit            lcd_done   = 1'b0;
   int            p_cpu, p_we, p_lcd;

   initial begin
      bit            free, lcd_pri, e_lg, e_cg, e_rd, e_wr, e_stall;
      logic [AW-1:0] e_addr;
      logic [DW-1:0] e_wdata;
      for (int a = 0; a < 64; a++) model_mem[a] = init_val(6'(a));

      rst = 1'b1; cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h10; cpu_wdata = 32'hDEADBEEF;
      lcd_req = 1'b1; lcd_addr = 32'h20;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_cpu_gnt", {63'd0, cpu_gnt}, 64'd0);
      chk("rst_lcd_gnt", {63'd0, lcd_gnt}, 64'd0);
      chk("rst_mem_rd_en", {63'd0, mem_rd_en}, 64'd0);
      chk("rst_mem_wr_en", {63'd0, mem_wr_en}, 64'd0);
      chk("rst_cpu_rvalid", {63'd0, cpu_rvalid}, 64'd0);
      chk("rst_lcd_rvalid", {63'd0, lcd_rvalid}, 64'd0);
      chk("rst_cpu_rdata", 64'(cpu_rdata), 64'd0);
      chk("rst_lcd_rdata", 64'(lcd_rdata), 64'd0);
      cpu_req = 1'b0;
      lcd_req = 1'b0;
      mon_en  = 1'b1;

      for (int c = 0; c < NCYC; c++) begin
         if (c < 2000)      begin p_cpu = 50;  p_we = 50; p_lcd = 40; end
         else if (c < 4000) begin p_cpu = 100; p_we = 90; p_lcd = 70; end
         else               begin p_cpu = 70;  p_we = 20; p_lcd = 60; end
         @(posedge clk);
         #1;
         rst = ($urandom_range(149) == 0);
         if (!cpu_req || cpu_done) begin
            cpu_req   = ($urandom_range(99) < p_cpu);
            cpu_we    = ($urandom_range(99) < p_we);
            cpu_addr  = AW'($urandom_range(63));
            cpu_wdata = $urandom;
         end else if ($urandom_range(99) < 2) begin
            cpu_req = 1'b0;
         end
         if (!lcd_req || lcd_done) begin
            lcd_req  = ($urandom_range(99) < p_lcd);
            lcd_addr = AW'($urandom_range(63));
         end else if ($urandom_range(99) < 2) begin
            lcd_req = 1'b0;
         end

         @(negedge clk);
         free    = !rst && (cyc >= busy_until);
         lcd_pri = GUARD && (denied == STARVE_LIMIT);
         e_lg    = free && lcd_req && (!cpu_req || lcd_pri);
         e_cg    = free && cpu_req && !e_lg;
         e_rd    = e_lg || (e_cg && !cpu_we);
         e_wr    = e_cg && cpu_we;
         e_stall = cpu_req && !e_cg;
         e_addr  = e_lg ? lcd_addr : (e_cg ? cpu_addr : '0);
         e_wdata = e_wr ? cpu_wdata : '0;
         chk("cpu_gnt", {63'd0, cpu_gnt}, {63'd0, e_cg});
         chk("lcd_gnt", {63'd0, lcd_gnt}, {63'd0, e_lg});
         chk("cpu_stall", {63'd0, cpu_stall}, {63'd0, e_stall});
         chk("mem_rd_en", {63'd0, mem_rd_en}, {63'd0, e_rd});
         chk("mem_wr_en", {63'd0, mem_wr_en}, {63'd0, e_wr});
         chk("mem_addr", 64'(mem_addr), 64'(e_addr));
         chk("mem_wdata", 64'(mem_wdata), 64'(e_wdata));

         if (rst) begin
            busy_until = 0;
            denied     = 0;
         end else begin
            if (e_wr) model_mem[cpu_addr[5:0]] = cpu_wdata;
            if (e_rd) begin
               busy_until = cyc + RD_LAT + 1;
               exp_q.push_back('{e_lg, model_mem[e_addr[5:0]], cyc + RD_LAT + 1});
            end
            if (!lcd_req || e_lg) denied = 0;
            else if (free)        denied++;
         end
         cpu_done = e_cg;
         lcd_done = e_lg;
      end

      @(posedge clk);
      #1;
      rst     = 1'b0;
      cpu_req = 1'b0;
      lcd_req = 1'b0;
      repeat (RD_LAT + 3) @(posedge clk);
      @(negedge clk);
      chk("drain_outstanding", 64'(exp_q.size()), 64'd0);
      mon_en = 1'b0;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
